multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the single-ALU RV32I datapath. It fetches each instruction through a request/acknowledge handshake and latches it into an internal instruction register. It then steps DECODE/EXEC/MEM/WB, driving the ALU's `ALUOp`/`ALUSrc`/`funct3`/`funct7` plus the PC, memory and register-file strobes. It sits between instruction memory, data memory and the datapath, and is the only sequencer of the ALU.

---
 rtl/multicycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the single-ALU RV32I datapath.
// Fetches into an internal IR, then steps DECODE/EXEC/MEM/WB driving ALU controls and strobes.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_instr,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        fetch_req,
    output logic [1:0]  ALUOp,
    output logic        ALUSrc,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        pc_write,
    output logic        pc_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [31:0] instret
);

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned CNT_W    = 32;

    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I_ALU  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_ALT      = 7'b0100000;
    localparam logic [6:0] F7_SRA_CODE = 7'd4;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;
    localparam logic [1:0] ALUOP_LUI    = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [INSTR_W-1:0]    r_ir;
    logic                  r_illegal;
    logic [CNT_W-1:0]      r_instret;

    logic [OPCODE_W-1:0]   w_opcode;
    logic [2:0]            w_f3;
    logic [6:0]            w_f7_raw;
    logic                  w_is_r;
    logic                  w_is_i;
    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_is_branch;
    logic                  w_is_lui;
    logic                  w_is_sub;
    logic                  w_legal;
    logic                  w_is_shift;
    logic [6:0]            w_funct7;
    logic [1:0]            w_alu_op;
    logic                  w_alu_src;
    logic                  w_unused_ir;

    // Instruction field decode from the latched IR
    assign w_opcode    = r_ir[6:0];
    assign w_f3        = r_ir[14:12];
    assign w_f7_raw    = r_ir[31:25];
    assign w_is_r      = (w_opcode == OP_R);
    assign w_is_i      = (w_opcode == OP_I_ALU);
    assign w_is_load   = (w_opcode == OP_LOAD);
    assign w_is_store  = (w_opcode == OP_STORE);
    assign w_is_branch = (w_opcode == OP_BRANCH);
    assign w_is_lui    = (w_opcode == OP_LUI);
    assign w_is_sub    = w_is_r && (w_f3 == 3'b000) && (w_f7_raw == F7_ALT);
    assign w_legal     = (w_is_r || w_is_i || w_is_load || w_is_store || w_is_branch || w_is_lui)
                         && !w_is_sub;
    assign w_unused_ir = ^{r_ir[24:15], r_ir[11:7]};

    // ALU shift encoding: arithmetic right shift is signalled as 4, logical shifts as 0
    assign w_is_shift = (w_is_r || w_is_i) && (w_f3[1:0] == 2'b01);
    assign w_funct7   = w_is_shift ? ((w_f3[2] && (w_f7_raw == F7_ALT)) ? F7_SRA_CODE : 7'd0)
                                   : w_f7_raw;

    always_comb begin
        w_alu_op  = ALUOP_ADD;
        w_alu_src = 1'b0;
        if (w_is_r) begin
            w_alu_op  = ALUOP_ARITH;
            w_alu_src = 1'b0;
        end else if (w_is_i) begin
            w_alu_op  = ALUOP_ARITH;
            w_alu_src = 1'b1;
        end else if (w_is_load || w_is_store) begin
            w_alu_op  = ALUOP_ADD;
            w_alu_src = 1'b1;
        end else if (w_is_lui) begin
            w_alu_op  = ALUOP_LUI;
            w_alu_src = 1'b1;
        end else if (w_is_branch) begin
            w_alu_op  = ALUOP_BRANCH;
            w_alu_src = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (fetch_ack) w_next = S_DECODE;
            S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (w_is_load || w_is_store) w_next = S_MEM;
                else if (w_is_branch)        w_next = S_FETCH;
                else                         w_next = S_WB;
            end
            S_MEM: begin
                if (mem_ready) w_next = w_is_load ? S_WB : S_FETCH;
            end
            S_WB:     w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // Control outputs; ALU controls stay stable from EXEC through WB
    always_comb begin
        fetch_req  = 1'b0;
        ALUOp      = 2'b00;
        ALUSrc     = 1'b0;
        funct3     = w_f3;
        funct7     = 7'd0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        case (r_state)
            S_FETCH: fetch_req = rst_n;
            S_EXEC: begin
                ALUOp  = w_alu_op;
                ALUSrc = w_alu_src;
                funct7 = w_funct7;
                if (w_is_branch) begin
                    pc_write = 1'b1;
                    pc_src   = zero;
                end
            end
            S_MEM: begin
                ALUOp     = w_alu_op;
                ALUSrc    = w_alu_src;
                funct7    = w_funct7;
                mem_read  = w_is_load;
                mem_write = w_is_store;
                pc_write  = w_is_store && mem_ready;
            end
            S_WB: begin
                ALUOp      = w_alu_op;
                ALUSrc     = w_alu_src;
                funct7     = w_funct7;
                reg_write  = 1'b1;
                mem_to_reg = w_is_load;
                pc_write   = 1'b1;
            end
            default: ;
        endcase
    end

    // State, IR, sticky illegal flag and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_FETCH) && fetch_ack) r_ir <= fetch_instr;
            if ((r_state == S_DECODE) && !w_legal) r_illegal <= 1'b1;
            if (pc_write) r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign illegal = r_illegal;
    assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected per-instruction behaviour is queued at drive time
// and compared when the instruction retires.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fetch_ack;
    logic [31:0] fetch_instr;
    logic        mem_ready;
    logic        zero;
    logic        fetch_req;
    logic [1:0]  ALUOp;
    logic        ALUSrc;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        pc_write;
    logic        pc_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        illegal;
    logic [31:0] instret;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .fetch_ack(fetch_ack), .fetch_instr(fetch_instr),
        .mem_ready(mem_ready), .zero(zero), .fetch_req(fetch_req), .ALUOp(ALUOp),
        .ALUSrc(ALUSrc), .funct3(funct3), .funct7(funct7), .pc_write(pc_write),
        .pc_src(pc_src), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cycles;
        int         rd_cnt;
        int         wr_cnt;
        logic [1:0] alu_op;
        logic       alu_src;
        logic [6:0] f7;
        logic       pc_src;
        logic       reg_wr;
        logic       m2r;
        bit         timeout;
    } rec_t;

    rec_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_instret = 32'd0;

    // Reference behaviour of one instruction, derived from opcode/funct fields
    function automatic rec_t model(input logic [31:0] instr, input int ack_wait, input int mem_wait,
                                   input logic z);
        rec_t       e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7r;
        opc = instr[6:0];
        f3  = instr[14:12];
        f7r = instr[31:25];
        e.rd_cnt = 0; e.wr_cnt = 0; e.pc_src = 1'b0; e.reg_wr = 1'b1; e.m2r = 1'b0;
        e.timeout = 1'b0; e.alu_op = 2'b10; e.alu_src = 1'b0; e.cycles = ack_wait + 4;
        case (opc)
            7'b0010011: e.alu_src = 1'b1;
            7'b0110111: begin e.alu_op = 2'b11; e.alu_src = 1'b1; end
            7'b0000011: begin
                e.alu_op = 2'b00; e.alu_src = 1'b1; e.m2r = 1'b1;
                e.rd_cnt = mem_wait + 1; e.cycles = ack_wait + 5 + mem_wait;
            end
            7'b0100011: begin
                e.alu_op = 2'b00; e.alu_src = 1'b1; e.reg_wr = 1'b0;
                e.wr_cnt = mem_wait + 1; e.cycles = ack_wait + 4 + mem_wait;
            end
            7'b1100011: begin
                e.alu_op = 2'b01; e.reg_wr = 1'b0; e.pc_src = z; e.cycles = ack_wait + 3;
            end
            default: ;
        endcase
        if ((opc == 7'b0110011 || opc == 7'b0010011) && (f3 == 3'b001 || f3 == 3'b101))
            e.f7 = (f3 == 3'b101 && f7r == 7'b0100000) ? 7'd4 : 7'd0;
        else
            e.f7 = f7r;
        return e;
    endfunction

    // Drive one instruction to retirement, with programmable ack/ready wait cycles
    task automatic run_instr(input logic [31:0] instr, input int ack_wait, input int mem_wait,
                             input logic z, output rec_t o);
        int fc = 0;
        int mc = 0;
        bit done = 1'b0;
        o.cycles = 0; o.rd_cnt = 0; o.wr_cnt = 0; o.alu_op = 2'b00; o.alu_src = 1'b0;
        o.f7 = 7'd0; o.pc_src = 1'b0; o.reg_wr = 1'b0; o.m2r = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            fetch_instr = instr;
            zero        = z;
            fetch_ack   = fetch_req && (fc == ack_wait);
            if (fetch_req) fc++;
            mem_ready   = (mem_read || mem_write) && (mc == mem_wait);
            if (mem_read || mem_write) mc++;
            if (mem_read) o.rd_cnt++;
            if (mem_write) o.wr_cnt++;
            #1;
            if (k == ack_wait + 2) begin
                o.alu_op = ALUOp; o.alu_src = ALUSrc; o.f7 = funct7;
            end
            if (pc_write) begin
                o.pc_src = pc_src; o.reg_wr = reg_write; o.m2r = mem_to_reg;
                o.cycles = k + 1; done = 1'b1;
            end
        end
        o.timeout = !done;
        @(negedge clk);
        fetch_ack = 1'b0;
        mem_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL reset_fetch_req: got %b want 0", fetch_req); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %h want 0", instret); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        checks++;
        if ({pc_write, mem_read, mem_write, reg_write, mem_to_reg, ALUOp, ALUSrc} !== 8'd0) begin
            errors++; $display("FAIL reset_strobes: got %b want 0",
                               {pc_write, mem_read, mem_write, reg_write, mem_to_reg, ALUOp, ALUSrc});
        end
        rst_n = 1'b1;
        #1;
        checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL release_fetch_req: got %b want 1", fetch_req); end
        exp_instret = 32'd0;
    endtask

    task automatic test_addi();
        rec_t o, e;
        exp_q.push_back(model(32'h00500093, 0, 0, 1'b0));
        run_instr(32'h00500093, 0, 0, 1'b0, o);
        e = exp_q.pop_front();
        exp_instret++;
        checks++; if (o.timeout) begin errors++; $display("FAIL addi_timeout: no pc_write within bound"); end
        checks++; if (o.cycles != e.cycles) begin errors++; $display("FAIL addi_cycles: got %0d want %0d", o.cycles, e.cycles); end
        checks++; if (o.alu_op !== e.alu_op || o.alu_src !== e.alu_src) begin
            errors++; $display("FAIL addi_alu: got %b/%b want %b/%b", o.alu_op, o.alu_src, e.alu_op, e.alu_src); end
        checks++; if (o.reg_wr !== e.reg_wr) begin errors++; $display("FAIL addi_reg_write: got %b want %b", o.reg_wr, e.reg_wr); end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL addi_instret: got %h want %h", instret, exp_instret); end
    endtask

    task automatic test_alu_ops();
        logic [31:0] ops [6] = '{32'h002081B3, 32'h4020D1B3, 32'h0020D1B3,
                                 32'h00309093, 32'h4020D093, 32'h123452B7};
        rec_t o, e;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(model(ops[i], i % 2, 0, 1'b0));
            run_instr(ops[i], i % 2, 0, 1'b0, o);
            e = exp_q.pop_front();
            exp_instret++;
            checks++; if (o.cycles != e.cycles) begin errors++; $display("FAIL alu_cycles[%0d]: got %0d want %0d", i, o.cycles, e.cycles); end
            checks++; if (o.alu_op !== e.alu_op || o.alu_src !== e.alu_src) begin
                errors++; $display("FAIL alu_ctrl[%0d]: got %b/%b want %b/%b", i, o.alu_op, o.alu_src, e.alu_op, e.alu_src); end
            checks++; if (o.f7 !== e.f7) begin errors++; $display("FAIL alu_funct7[%0d]: got %h want %h", i, o.f7, e.f7); end
            checks++; if (instret !== exp_instret) begin errors++; $display("FAIL alu_instret[%0d]: got %h want %h", i, instret, exp_instret); end
        end
    endtask

    task automatic test_load_store();
        logic [31:0] ops [3] = '{32'h0000A103, 32'h0000A103, 32'h0020A223};
        int          aw  [3] = '{0, 2, 0};
        int          mw  [3] = '{3, 0, 2};
        rec_t o, e;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(model(ops[i], aw[i], mw[i], 1'b0));
            run_instr(ops[i], aw[i], mw[i], 1'b0, o);
            e = exp_q.pop_front();
            exp_instret++;
            checks++; if (o.timeout || o.cycles != e.cycles) begin
                errors++; $display("FAIL mem_cycles[%0d]: got %0d want %0d", i, o.cycles, e.cycles); end
            checks++; if (o.rd_cnt != e.rd_cnt || o.wr_cnt != e.wr_cnt) begin
                errors++; $display("FAIL mem_strobe_len[%0d]: got rd=%0d wr=%0d want rd=%0d wr=%0d",
                                   i, o.rd_cnt, o.wr_cnt, e.rd_cnt, e.wr_cnt); end
            checks++; if (o.m2r !== e.m2r || o.reg_wr !== e.reg_wr) begin
                errors++; $display("FAIL mem_wb[%0d]: got m2r=%b rw=%b want m2r=%b rw=%b", i, o.m2r, o.reg_wr, e.m2r, e.reg_wr); end
            checks++; if (instret !== exp_instret) begin errors++; $display("FAIL mem_instret[%0d]: got %h want %h", i, instret, exp_instret); end
        end
    endtask

    task automatic test_branch();
        rec_t o, e;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(model(32'h00208463, 0, 0, 1'(1 - i)));
            run_instr(32'h00208463, 0, 0, 1'(1 - i), o);
            e = exp_q.pop_front();
            exp_instret++;
            checks++; if (o.cycles != e.cycles) begin errors++; $display("FAIL beq_cycles[%0d]: got %0d want %0d", i, o.cycles, e.cycles); end
            checks++; if (o.pc_src !== e.pc_src) begin errors++; $display("FAIL beq_pc_src[%0d]: got %b want %b", i, o.pc_src, e.pc_src); end
            checks++; if (o.alu_op !== e.alu_op || o.reg_wr !== e.reg_wr) begin
                errors++; $display("FAIL beq_ctrl[%0d]: got op=%b rw=%b want op=%b rw=%b", i, o.alu_op, o.reg_wr, e.alu_op, e.reg_wr); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops [8] = '{32'h00500093, 32'h0000A103, 32'h0020A223, 32'h00208463,
                                 32'h4020D1B3, 32'h123452B7, 32'h0020D463, 32'h0000A103};
        int   aw, mw;
        logic z;
        rec_t o, e;
        for (int i = 0; i < 8; i++) begin
            aw = int'($urandom_range(0, 2));
            mw = int'($urandom_range(0, 2));
            z  = 1'($urandom_range(0, 1));
            exp_q.push_back(model(ops[i], aw, mw, z));
            run_instr(ops[i], aw, mw, z, o);
            e = exp_q.pop_front();
            exp_instret++;
            checks++; if (o.timeout || o.cycles != e.cycles) begin
                errors++; $display("FAIL b2b_cycles[%0d]: got %0d want %0d", i, o.cycles, e.cycles); end
            checks++; if (o.pc_src !== e.pc_src || o.f7 !== e.f7) begin
                errors++; $display("FAIL b2b_ctrl[%0d]: got src=%b f7=%h want src=%b f7=%h", i, o.pc_src, o.f7, e.pc_src, e.f7); end
            checks++; if (instret !== exp_instret) begin errors++; $display("FAIL b2b_instret[%0d]: got %h want %h", i, instret, exp_instret); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ops [2] = '{32'h40000033, 32'h0000006F};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); fetch_instr = ops[i]; fetch_ack = 1'b1;
            @(negedge clk); fetch_ack = 1'b0;
            @(negedge clk); #1;
            checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag[%0d]: got %b want 1", i, illegal); end
            for (int k = 0; k < 3; k++) begin
                @(negedge clk); fetch_ack = 1'b1; #1;
                checks++; if (fetch_req !== 1'b0 || pc_write !== 1'b0 || instret !== exp_instret) begin
                    errors++; $display("FAIL halt_quiet[%0d.%0d]: got req=%b pcw=%b instret=%h want 0/0/%h",
                                       i, k, fetch_req, pc_write, instret, exp_instret); end
            end
            fetch_ack = 1'b0;
            rst_n = 1'b0; #1;
            checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_cleared[%0d]: got %b want 0", i, illegal); end
            exp_instret = 32'd0;
            @(negedge clk); rst_n = 1'b1;
        end
    endtask

    task automatic test_reset_mid_mem();
        @(negedge clk); fetch_instr = 32'h0020A223; fetch_ack = 1'b1;
        @(negedge clk); fetch_ack = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL store_wait_mem_write: got %b want 1", mem_write); end
        #2 rst_n = 1'b0; #1;
        checks++; if (mem_write !== 1'b0 || fetch_req !== 1'b0) begin
            errors++; $display("FAIL async_reset: got wr=%b req=%b want 0/0", mem_write, fetch_req); end
        exp_instret = 32'd0;
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL post_reset_fetch: got %b want 1", fetch_req); end
    endtask

    task automatic test_wrap();
        rec_t o, e;
        @(negedge clk);
        force dut.r_instret = 32'hFFFF_FFFF;
        #1 release dut.r_instret;
        #1;
        exp_instret = 32'hFFFF_FFFF;
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL wrap_preset: got %h want %h", instret, exp_instret); end
        exp_q.push_back(model(32'h00500093, 0, 0, 1'b0));
        run_instr(32'h00500093, 0, 0, 1'b0, o);
        e = exp_q.pop_front();
        exp_instret++;
        checks++; if (o.cycles != e.cycles) begin errors++; $display("FAIL wrap_cycles: got %0d want %0d", o.cycles, e.cycles); end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL wrap_instret: got %h want %h", instret, exp_instret); end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; fetch_ack = 1'b0; fetch_instr = 32'd0;
        mem_ready = 1'b0; zero = 1'b0;
        test_reset();
        test_addi();
        test_alu_ops();
        test_load_store();
        test_branch();
        test_back_to_back();
        test_illegal();
        test_reset_mid_mem();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
